// File: rtl/soundbar_pkg.sv
// soundbar_pkg: shared types, OLED geometry and level-width helper for the
// segmented sound-bar renderer.
package soundbar_pkg;

  // One RGB565 pixel colour.
  typedef logic [15:0] rgb565_t;

  // Native OLED panel geometry.
  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  // Bits needed to hold a level in 0..levels inclusive.
  function automatic int lvl_width(input int levels);
    return $clog2(levels + 1);
  endfunction

endpackage : soundbar_pkg

// File: rtl/soundbar_chan_dyn.sv
// soundbar_chan_dyn: per-channel bar dynamics. Instant attack, one segment of
// release every DECAY_FRAMES frames. With SOUNDBAR_PEAK_HOLD_EN defined, a
// peak marker is also tracked: it holds for HOLD_FRAMES frames, then falls one
// segment per frame but never below the displayed level.
// State only advances on frame_tick, so level changes between ticks are ignored.
module soundbar_chan_dyn
  import soundbar_pkg::*;
#(
  parameter int LEVELS       = 16,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30,
  localparam int LW          = lvl_width(LEVELS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic [LW-1:0] level,
  output logic [LW-1:0] disp
`ifdef SOUNDBAR_PEAK_HOLD_EN
  ,
  output logic [LW-1:0] peak
`endif
);

  localparam int FW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [LW-1:0] LMAX = LW'(LEVELS);
  localparam logic [FW-1:0] FMAX = FW'(DECAY_FRAMES - 1);

  logic [LW-1:0] in_sat;
  logic [LW-1:0] disp_q, disp_n;
  logic [FW-1:0] fall_q, fall_n;

`ifdef SOUNDBAR_PEAK_HOLD_EN
  localparam logic [HW-1:0] HMAX = HW'(HOLD_FRAMES);
  logic [LW-1:0] peak_q, peak_n, peak_dec;
  logic [HW-1:0] hold_q, hold_n;
`else
  logic [HW-1:0] unused_hold_w;
  assign unused_hold_w = '0;
`endif

  // Next-state for the displayed level and, when enabled, the peak marker.
  always_comb begin
    in_sat = (level > LMAX) ? LMAX : level;
    disp_n = disp_q;
    fall_n = fall_q;
    if (frame_tick) begin
      if (in_sat >= disp_q) begin
        disp_n = in_sat;
        fall_n = '0;
      end else if (fall_q == FMAX) begin
        // in_sat < disp_q here, so disp_q is at least 1 and cannot underflow.
        disp_n = disp_q - 1'b1;
        fall_n = '0;
      end else begin
        fall_n = fall_q + 1'b1;
      end
    end
`ifdef SOUNDBAR_PEAK_HOLD_EN
    peak_n   = peak_q;
    hold_n   = hold_q;
    peak_dec = peak_q - 1'b1;
    if (frame_tick) begin
      if (in_sat >= peak_q) begin
        peak_n = in_sat;
        hold_n = '0;
      end else if (hold_q < HMAX) begin
        hold_n = hold_q + 1'b1;
      end else begin
        // in_sat < peak_q, so peak_q >= 1 and peak_dec is meaningful.
        peak_n = (peak_dec > disp_n) ? peak_dec : disp_n;
      end
    end
`endif
  end

  // State registers; reset wins over a coincident frame_tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_q <= '0;
      fall_q <= '0;
`ifdef SOUNDBAR_PEAK_HOLD_EN
      peak_q <= '0;
      hold_q <= '0;
`endif
    end else begin
      disp_q <= disp_n;
      fall_q <= fall_n;
`ifdef SOUNDBAR_PEAK_HOLD_EN
      peak_q <= peak_n;
      hold_q <= hold_n;
`endif
    end
  end

  assign disp = disp_q;
`ifdef SOUNDBAR_PEAK_HOLD_EN
  assign peak = peak_q;
`endif

endmodule : soundbar_chan_dyn

// File: rtl/soundbar_meter.sv
// soundbar_meter: renders NCH vertical segmented level bars into the RGB565
// pixel stream, one pixel per clock with one cycle of latency.
// Optional feature macro: SOUNDBAR_PEAK_HOLD_EN (peak-hold marker in col_peak).
module soundbar_meter
  import soundbar_pkg::*;
#(
  parameter int WIDTH        = OLED_WIDTH,
  parameter int HEIGHT       = OLED_HEIGHT,
  parameter int NCH          = 1,
  parameter int LEVELS       = 16,
  parameter int SEG_H        = 4,
  parameter int BAR_X0       = 32,
  parameter int BAR_W        = 32,
  parameter int BAR_PITCH    = 40,
  parameter int LOW_SEGS     = 6,
  parameter int MID_SEGS     = 5,
  parameter int DECAY_FRAMES = 4,
  parameter int HOLD_FRAMES  = 30,
  localparam int LW          = lvl_width(LEVELS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [NCH*LW-1:0] level_in,
  input  logic [12:0]       pixel_index,
  input  rgb565_t           col_bg,
  input  rgb565_t           col_low,
  input  rgb565_t           col_mid,
  input  rgb565_t           col_high,
  input  rgb565_t           col_peak,
  output rgb565_t           data,
  output logic [NCH*LW-1:0] disp_level
);

  logic [LW-1:0] disp_arr [NCH];
`ifdef SOUNDBAR_PEAK_HOLD_EN
  logic [LW-1:0] peak_arr [NCH];
  int            sel_peak;
`else
  rgb565_t unused_col_peak;
  assign unused_col_peak = col_peak;
`endif

  // One dynamics engine per channel; channel 0 sits in the LSBs.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    soundbar_chan_dyn #(
      .LEVELS       (LEVELS),
      .DECAY_FRAMES (DECAY_FRAMES),
      .HOLD_FRAMES  (HOLD_FRAMES)
    ) u_dyn (
      .clock      (clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .level      (level_in[c*LW +: LW]),
      .disp       (disp_arr[c])
`ifdef SOUNDBAR_PEAK_HOLD_EN
      ,
      .peak       (peak_arr[c])
`endif
    );
    assign disp_level[c*LW +: LW] = disp_arr[c];
  end

  int      px_idx;
  int      px_x;
  int      px_row;
  int      px_b;
  int      px_seg;
  int      sel_disp;
  logic    px_hit;
  logic    px_valid;
  rgb565_t pix_col;

  // Pixel decode: bar-relative row/segment, owning channel, then colour mux.
  always_comb begin
    px_idx   = int'(pixel_index);
    px_x     = px_idx % WIDTH;
    px_row   = px_idx / WIDTH;
    px_b     = HEIGHT - 1 - px_row;
    px_seg   = px_b / SEG_H + 1;
    px_hit   = 1'b0;
    sel_disp = 0;
`ifdef SOUNDBAR_PEAK_HOLD_EN
    sel_peak = 0;
`endif
    // Scan upwards and latch the first hit so the lowest channel owns overlaps.
    for (int c = 0; c < NCH; c++) begin
      if (!px_hit && px_x >= BAR_X0 + c * BAR_PITCH &&
          px_x < BAR_X0 + c * BAR_PITCH + BAR_W) begin
        px_hit   = 1'b1;
        sel_disp = int'(disp_arr[c]);
`ifdef SOUNDBAR_PEAK_HOLD_EN
        sel_peak = int'(peak_arr[c]);
`endif
      end
    end
    px_valid = (px_idx < WIDTH * HEIGHT) && px_hit &&
               (px_b % SEG_H != SEG_H - 1) && (px_seg <= LEVELS);
    pix_col = col_bg;
    if (px_valid) begin
      if (px_seg <= sel_disp) begin
        if (px_seg <= LOW_SEGS)                 pix_col = col_low;
        else if (px_seg <= LOW_SEGS + MID_SEGS) pix_col = col_mid;
        else                                    pix_col = col_high;
      end
`ifdef SOUNDBAR_PEAK_HOLD_EN
      else if (px_seg == sel_peak && sel_peak > sel_disp) begin
        pix_col = col_peak;
      end
`endif
    end
  end

  // Output register gives the one-cycle pixel latency.
  always_ff @(posedge clock) begin
    if (reset) data <= '0;
    else       data <= pix_col;
  end

endmodule : soundbar_meter

// File: tb/tb_soundbar_meter.sv
// tb_soundbar_meter: directed + randomized bench for soundbar_meter with a
// single-channel instance and a two-channel instance sharing the pixel stream.
`timescale 1ns/1ps
module tb_soundbar_meter;
  import soundbar_pkg::*;

  localparam int LW = 5;
  localparam logic [15:0] C_BG   = 16'h0841;
  localparam logic [15:0] C_LOW  = 16'h07E0;
  localparam logic [15:0] C_MID  = 16'hFFE0;
  localparam logic [15:0] C_HIGH = 16'hF800;
  localparam logic [15:0] C_PEAK = 16'h001F;

  // ---------------- clock / reset / DUTs ----------------
  logic            clock = 1'b0;
  logic            reset;
  logic            frame_tick;
  logic [LW-1:0]   level_in;
  logic [2*LW-1:0] level_in2;
  logic [12:0]     pixel_index;
  rgb565_t         col_bg, col_low, col_mid, col_high, col_peak;
  rgb565_t         data, data2;
  logic [LW-1:0]   disp_level;
  logic [2*LW-1:0] disp_level2;

  always #5 clock = ~clock;

  soundbar_meter dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .level_in(level_in), .pixel_index(pixel_index),
    .col_bg(col_bg), .col_low(col_low), .col_mid(col_mid),
    .col_high(col_high), .col_peak(col_peak),
    .data(data), .disp_level(disp_level)
  );

  soundbar_meter #(.NCH(2)) dut2 (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .level_in(level_in2), .pixel_index(pixel_index),
    .col_bg(col_bg), .col_low(col_low), .col_mid(col_mid),
    .col_high(col_high), .col_peak(col_peak),
    .data(data2), .disp_level(disp_level2)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  // Reference model, index 0 = dut ch0, 1 = dut2 ch0, 2 = dut2 ch1.
  // Displayed level = last attack value minus one per DECAY(4) quiet frames.
  int mv[3];  // value captured at last attack
  int mn[3];  // frames since last attack
  int mp[3];  // peak marker level
  int mh[3];  // hold frames elapsed

  function automatic int m_disp(input int k);
    int d;
    d = mv[k] - mn[k] / 4;
    return (d < 0) ? 0 : d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mn[k] = 0; mp[k] = 0; mh[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int lvl);
    int inc, d_next;
    inc = (lvl > 16) ? 16 : lvl;
    if (inc >= m_disp(k)) begin
      mv[k] = inc; mn[k] = 0;
    end else begin
      mn[k]++;
    end
    d_next = m_disp(k);
    if (inc >= mp[k]) begin
      mp[k] = inc; mh[k] = 0;
    end else if (mh[k] < 30) begin
      mh[k]++;
    end else begin
      mp[k] = (mp[k] - 1 > d_next) ? mp[k] - 1 : d_next;
    end
  endtask

  function automatic logic [15:0] exp_colour(input int base, input int nch, input int idx);
    int x, b, seg, owner;
    if (idx >= 96 * 64) return C_BG;
    x = idx % 96;
    b = 63 - idx / 96;
    if (b % 4 == 3) return C_BG;
    seg = b / 4 + 1;
    owner = -1;
    for (int c = nch - 1; c >= 0; c--)
      if (x >= 32 + 40 * c && x < 64 + 40 * c) owner = c;
    if (owner < 0) return C_BG;
    if (seg <= m_disp(base + owner)) begin
      if (seg <= 6) return C_LOW;
      if (seg <= 11) return C_MID;
      return C_HIGH;
    end
`ifdef SOUNDBAR_PEAK_HOLD_EN
    if (seg == mp[base + owner] && mp[base + owner] > m_disp(base + owner)) return C_PEAK;
`endif
    return C_BG;
  endfunction

  // Pixel index of segment s (lowest drawn row of that segment) at column x.
  function automatic int seg_idx(input int s, input int x);
    return (63 - (s - 1) * 4) * 96 + x;
  endfunction

  // ---------------- comparison ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; frame_tick = 1'b1;
    level_in = 5'd16; level_in2 = {5'd16, 5'd16};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_data2", 32'(data2), 32'h0);
    chk("rst_disp", 32'(disp_level), 32'h0);
    chk("rst_disp2", 32'(disp_level2), 32'h0);
    reset = 1'b0; frame_tick = 1'b0;
    model_reset();
  endtask

  task automatic tick(input int l0, input int l1, input int l2);
    level_in   = LW'(l0);
    level_in2  = {LW'(l2), LW'(l1)};
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    model_step(0, l0); model_step(1, l1); model_step(2, l2);
  endtask

  task automatic check_levels(input string tag);
    chk({tag, "_lvl1"}, 32'(disp_level), 32'(m_disp(0)));
    chk({tag, "_lvl2"}, 32'(disp_level2), 32'((m_disp(2) << 5) | m_disp(1)));
  endtask

  // Levels are scrambled while no tick is pending; they must have no effect.
  task automatic check_pixel(input string tag, input int idx);
    logic [15:0] e;
    pixel_index = 13'(idx);
    level_in    = LW'($urandom_range(0, 31));
    level_in2   = 10'($urandom);
    exp_q.push_back(exp_colour(0, 1, idx));
    exp_q.push_back(exp_colour(1, 2, idx));
    @(posedge clock); #1;
    e = exp_q.pop_front();
    chk({tag, "_d1"}, 32'(data), 32'(e));
    e = exp_q.pop_front();
    chk({tag, "_d2"}, 32'(data2), 32'(e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, b2, c2;
    reset = 1'b0; frame_tick = 1'b0; level_in = '0; level_in2 = '0; pixel_index = '0;
    col_bg = C_BG; col_low = C_LOW; col_mid = C_MID; col_high = C_HIGH; col_peak = C_PEAK;
    model_reset();

    // 1: reset overrides tick, first tick after release attacks to 16
    do_reset();
    tick(16, 16, 16);
    chk("t1_disp16", 32'(disp_level), 32'd16);
    check_levels("t1");

    // 2: level 1 geometry
    do_reset();
    tick(1, 1, 1);
    check_pixel("t2_low", 5896);
    check_pixel("t2_gap", 5800);
    check_pixel("t2_left", 5878);

    // 3: full scale colours, top gap, out of range
    do_reset();
    tick(16, 16, 16);
    check_pixel("t3_high", 136);
    check_pixel("t3_mid", 2536);
    check_pixel("t3_gap0", 0);
    check_pixel("t3_oor", 6200);

    // 4: release timing and saturation
    do_reset();
    tick(16, 16, 16);
    for (int k = 0; k < 4; k++) tick(0, 0, 0);
    chk("t4_disp15", 32'(disp_level), 32'd15);
    check_levels("t4a");
    for (int k = 0; k < 60; k++) tick(0, 0, 0);
    chk("t4_disp0", 32'(disp_level), 32'd0);
    tick(20, 31, 17);
    chk("t4_sat", 32'(disp_level), 32'd16);
    check_levels("t4b");

`ifdef SOUNDBAR_PEAK_HOLD_EN
    // 5: peak hold then fall towards the displayed level
    do_reset();
    tick(10, 10, 10);
    for (int k = 1; k <= 45; k++) begin
      tick(0, 0, 0);
      check_levels("t5");
      check_pixel("t5_2536", 2536);
      if (mp[0] > 0) check_pixel("t5_pkseg", seg_idx(mp[0], 40));
    end
`endif

    // 6: two channels, gap columns between bars
    do_reset();
    tick(0, 12, 4);
    check_levels("t6");
    check_pixel("t6_c0_top", seg_idx(12, 40));
    check_pixel("t6_c0_above", seg_idx(13, 40));
    check_pixel("t6_c1_top", seg_idx(4, 80));
    check_pixel("t6_c1_above", seg_idx(5, 80));
    for (int x = 64; x <= 71; x++) check_pixel("t6_between", seg_idx(1, x));
    for (int x = 72; x <= 75; x++) check_pixel("t6_c1_high", seg_idx(8, x));

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 160; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 16));
      b2 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : 0;
      c2 = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : 0;
      tick(a, b2, c2);
      check_levels("rnd");
      check_pixel("rnd_bar", seg_idx($urandom_range(1, 16), $urandom_range(0, 95)) - 96 * $urandom_range(0, 2));
      check_pixel("rnd_any", $urandom_range(0, 6400));
      if (n == 80) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_soundbar_meter
